// File: rtl/alu_issue_queue_pkg.sv
// Shared ALU opcode encodings and default sizing for the ALU issue queue.
package alu_issue_queue_pkg;

  localparam int ALU_OP_WIDTH   = 4;
  localparam int ROB_SIZE_WIDTH = 3;
  localparam int RS_SIZE        = 8;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_OR   = 4'd3,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_SLL  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SRA  = 4'd7,
    ALU_OP_SLT  = 4'd8,
    ALU_OP_SLTU = 4'd9,
    ALU_OP_BEQ  = 4'd10,
    ALU_OP_BNE  = 4'd11,
    ALU_OP_BLT  = 4'd12,
    ALU_OP_BGE  = 4'd13,
    ALU_OP_BLTU = 4'd14,
    ALU_OP_BGEU = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_issue_queue_rs_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
// Age matrix is flattened row-major; bit [j*N+i] set means entry j is older than entry i.
module alu_issue_queue_rs_age_select #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_ready,
  input  logic [N*N-1:0]   i_age,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_idx;

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    logic [N-1:0] w_older;
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign w_older[gj] = i_ready[gj] & i_age[gj*N + gi];
    end
    assign w_grant[gi] = i_ready[gi] & ~|w_older;
  end

  // Grant is one-hot, so OR-ing the indices of set bits is a binary encode.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) w_idx = w_idx | IDX_W'(i);
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;
  assign o_any   = |i_ready;

endmodule

// File: rtl/alu_issue_queue.sv
// Age-ordered ALU reservation station with multi-channel CDB wakeup and insert bypass,
// issuing the oldest ready entry through a valid/ready output register.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int RS_DEPTH  = RS_SIZE,
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = ROB_SIZE_WIDTH,
  parameter int OP_W      = ALU_OP_WIDTH,
  parameter int NUM_CDB   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            stall,
  input  logic                            in_valid,
  input  logic [OP_W-1:0]                 in_op,
  input  logic [ROB_IDX_W-1:0]            in_rob_id,
  input  logic                            in_rdy1,
  input  logic [XLEN-1:0]                 in_val1,
  input  logic [ROB_IDX_W-1:0]            in_tag1,
  input  logic                            in_rdy2,
  input  logic [XLEN-1:0]                 in_val2,
  input  logic [ROB_IDX_W-1:0]            in_tag2,
  input  logic [NUM_CDB-1:0]              cdb_valid,
  input  logic [NUM_CDB*ROB_IDX_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]         cdb_val,
  output logic                            rs_full,
  output logic [$clog2(RS_DEPTH+1)-1:0]   rs_count,
  output logic                            iss_valid,
  input  logic                            iss_ready,
  output logic [OP_W-1:0]                 iss_op,
  output logic [XLEN-1:0]                 iss_val1,
  output logic [XLEN-1:0]                 iss_val2,
  output logic [ROB_IDX_W-1:0]            iss_rob_id
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH+1);

  logic [RS_DEPTH-1:0]  r_busy, r_rdy1, r_rdy2;
  logic [RS_DEPTH-1:0]  r_age  [RS_DEPTH];
  logic [OP_W-1:0]      r_op   [RS_DEPTH];
  logic [ROB_IDX_W-1:0] r_rob  [RS_DEPTH];
  logic [ROB_IDX_W-1:0] r_tag1 [RS_DEPTH];
  logic [ROB_IDX_W-1:0] r_tag2 [RS_DEPTH];
  logic [XLEN-1:0]      r_val1 [RS_DEPTH];
  logic [XLEN-1:0]      r_val2 [RS_DEPTH];

  logic                 r_iss_valid;
  logic [OP_W-1:0]      r_iss_op;
  logic [XLEN-1:0]      r_iss_val1, r_iss_val2;
  logic [ROB_IDX_W-1:0] r_iss_rob;

  logic [RS_DEPTH-1:0]          w_ready, w_grant, w_ins;
  logic [RS_DEPTH*RS_DEPTH-1:0] w_age_flat;
  logic [IDX_W-1:0]             w_grant_idx, w_free_idx;
  logic                         w_any_ready, w_load, w_issue, w_accept, w_full;
  logic [CNT_W-1:0]             w_count;
  logic [XLEN:0]                w_wk1 [RS_DEPTH];
  logic [XLEN:0]                w_wk2 [RS_DEPTH];
  logic [XLEN:0]                w_byp1, w_byp2;

  // Returns {hit, value}; scanning high to low lets the lowest matching channel win.
  function automatic logic [XLEN:0] cdb_lookup(input logic [ROB_IDX_W-1:0] tag);
    logic [XLEN:0] res;
    res = '0;
    for (int k = NUM_CDB-1; k >= 0; k--) begin
      if (cdb_valid[k] && (cdb_tag[k*ROB_IDX_W +: ROB_IDX_W] == tag))
        res = {1'b1, cdb_val[k*XLEN +: XLEN]};
    end
    return res;
  endfunction

  assign w_ready  = r_busy & r_rdy1 & r_rdy2;
  assign w_load   = ~r_iss_valid | iss_ready;
  assign w_issue  = w_load & w_any_ready;
  assign w_full   = (w_count == CNT_W'(RS_DEPTH));
  assign w_accept = in_valid & ~stall & ~w_full & ~flush;
  assign w_byp1   = cdb_lookup(in_tag1);
  assign w_byp2   = cdb_lookup(in_tag2);

  always_comb begin
    w_count = '0;
    for (int i = 0; i < RS_DEPTH; i++) w_count = w_count + CNT_W'(r_busy[i]);
  end

  // Lowest free slot, judged on registered busy so a slot issued this cycle stays taken.
  always_comb begin
    w_free_idx = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
    end
  end

  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_ent
    assign w_ins[gi] = w_accept && (w_free_idx == IDX_W'(gi));
    assign w_wk1[gi] = cdb_lookup(r_tag1[gi]);
    assign w_wk2[gi] = cdb_lookup(r_tag2[gi]);
    assign w_age_flat[gi*RS_DEPTH +: RS_DEPTH] = r_age[gi];
  end

  alu_issue_queue_rs_age_select #(
    .N     (RS_DEPTH),
    .IDX_W (IDX_W)
  ) u_sel (
    .i_ready (w_ready),
    .i_age   (w_age_flat),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= '0;
      r_rdy1      <= '0;
      r_rdy2      <= '0;
      r_iss_valid <= 1'b0;
      r_iss_op    <= '0;
      r_iss_val1  <= '0;
      r_iss_val2  <= '0;
      r_iss_rob   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) r_age[i] <= '0;
    end else if (flush) begin
      r_busy      <= '0;
      r_iss_valid <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) r_age[i] <= '0;
    end else begin
      if (w_load) begin
        r_iss_valid <= w_any_ready;
        if (w_any_ready) begin
          r_iss_op   <= r_op[w_grant_idx];
          r_iss_val1 <= r_val1[w_grant_idx];
          r_iss_val2 <= r_val2[w_grant_idx];
          r_iss_rob  <= r_rob[w_grant_idx];
        end
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (w_ins[i]) begin
          r_busy[i] <= 1'b1;
          r_rdy1[i] <= in_rdy1 | w_byp1[XLEN];
          r_rdy2[i] <= in_rdy2 | w_byp2[XLEN];
          r_age[i]  <= '0;
        end else begin
          if (w_issue && w_grant[i]) r_busy[i] <= 1'b0;
          if (r_busy[i] && !r_rdy1[i] && w_wk1[i][XLEN]) r_rdy1[i] <= 1'b1;
          if (r_busy[i] && !r_rdy2[i] && w_wk2[i][XLEN]) r_rdy2[i] <= 1'b1;
          if (w_accept) r_age[i][w_free_idx] <= r_busy[i];
        end
      end
    end
  end

  // Payload is qualified by busy/rdy, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (w_ins[i]) begin
        r_op[i]   <= in_op;
        r_rob[i]  <= in_rob_id;
        r_tag1[i] <= in_tag1;
        r_tag2[i] <= in_tag2;
        r_val1[i] <= in_rdy1 ? in_val1 : w_byp1[XLEN-1:0];
        r_val2[i] <= in_rdy2 ? in_val2 : w_byp2[XLEN-1:0];
      end else begin
        if (r_busy[i] && !r_rdy1[i] && w_wk1[i][XLEN]) r_val1[i] <= w_wk1[i][XLEN-1:0];
        if (r_busy[i] && !r_rdy2[i] && w_wk2[i][XLEN]) r_val2[i] <= w_wk2[i][XLEN-1:0];
      end
    end
  end

  assign rs_full    = w_full;
  assign rs_count   = w_count;
  assign iss_valid  = r_iss_valid;
  assign iss_op     = r_iss_op;
  assign iss_val1   = r_iss_val1;
  assign iss_val2   = r_iss_val2;
  assign iss_rob_id = r_iss_rob;

endmodule
